// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, predictor-steered next PC and a
// 2-entry decoupling FIFO between fetch and decode. Slot 0 is always the head.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bpPc,
  input  logic        bpHit,
  input  logic [31:0] bpTarget,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        ifValid,
  input  logic        ifReady,
  output logic [31:0] ifInstr,
  output logic [31:0] ifPc,
  output logic        ifPredTaken,
  output logic [31:0] ifPredTarget
);

  // Entry layout: {pc, instr, predTaken, predTarget}
  localparam int EW = 97;

  logic [31:0]   pc_q, pc_d;
  logic [1:0]    count_q, count_d;
  logic [EW-1:0] slot0_q, slot0_d;
  logic [EW-1:0] slot1_q, slot1_d;
  logic          deq, fetch_en, enq;
  logic [31:0]   next_pc;
  logic [EW-1:0] new_ent;

  assign bpPc     = pc_q;
  assign imemAddr = pc_q;
  assign ifValid  = (count_q != 2'd0);
  assign {ifPc, ifInstr, ifPredTaken, ifPredTarget} = slot0_q;

  assign deq      = ifValid && ifReady;
  assign fetch_en = (count_q != 2'd2) || deq;
  assign enq      = fetch_en && !redirect;
  assign next_pc  = bpHit ? {bpTarget[31:2], 2'b00} : pc_q + 32'd4;
  assign new_ent  = {pc_q, imemRdata, bpHit, bpTarget};

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (redirect) begin
      // Flush wins over everything; a same-cycle dequeue is still consumed.
      count_d = 2'd0;
      pc_d    = {redirectPc[31:2], 2'b00};
    end else begin
      if (enq) pc_d = next_pc;
      case ({enq, deq})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = new_ent;
          else                 slot1_d = new_ent;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = new_ent;
          end else begin
            slot0_d = slot1_q;
            slot1_d = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push hand-computed
// decode-side entries; a monitor pops and compares on every accepted entry.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        tk;
    logic [31:0] tg;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rstB;
  logic        ifReady, readyB;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        hit_en;
  logic [31:0] hit_pc, hit_tgt;

  logic [31:0] bpPc, bpTarget, imemAddr, imemRdata, ifInstr, ifPc, ifPredTarget;
  logic        bpHit, ifValid, ifPredTaken;

  logic [31:0] bpPcB, bpTargetB, imemAddrB, imemRdataB, ifInstrB, ifPcB, ifPredTargetB;
  logic        bpHitB, ifValidB, ifPredTakenB, redirectB;
  logic [31:0] redirectPcB;

  assign bpHit      = hit_en && (bpPc == hit_pc);
  assign bpTarget   = bpHit ? hit_tgt : 32'h0;
  assign imemRdata  = imemAddr ^ 32'hA5A5_0000;
  assign bpHitB     = 1'b0;
  assign bpTargetB  = 32'h0;
  assign imemRdataB = imemAddrB ^ 32'hA5A5_0000;
  assign redirectB  = 1'b0;
  assign redirectPcB = 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bpPc(bpPc), .bpHit(bpHit), .bpTarget(bpTarget),
    .imemAddr(imemAddr), .imemRdata(imemRdata), .redirect(redirect),
    .redirectPc(redirectPc), .ifValid(ifValid), .ifReady(ifReady),
    .ifInstr(ifInstr), .ifPc(ifPc), .ifPredTaken(ifPredTaken),
    .ifPredTarget(ifPredTarget)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rstB), .bpPc(bpPcB), .bpHit(bpHitB), .bpTarget(bpTargetB),
    .imemAddr(imemAddrB), .imemRdata(imemRdataB), .redirect(redirectB),
    .redirectPc(redirectPcB), .ifValid(ifValidB), .ifReady(readyB),
    .ifInstr(ifInstrB), .ifPc(ifPcB), .ifPredTaken(ifPredTakenB),
    .ifPredTarget(ifPredTargetB)
  );

  int   total = 0;
  int   bad   = 0;
  int   deqA  = 0;
  int   deqB  = 0;
  ent_t qa[$];
  ent_t qb[$];

  function automatic ent_t mk(logic [31:0] pc, logic tk, logic [31:0] tg);
    ent_t e;
    e.pc    = pc;
    e.instr = pc ^ 32'hA5A5_0000;
    e.tk    = tk;
    e.tg    = tg;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic score(string nm, ent_t act, inout ent_t q[$]);
    ent_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected entry pc=%h, expected none", nm, act.pc);
    end else begin
      e = q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got pc=%h instr=%h tk=%b tg=%h expected pc=%h instr=%h tk=%b tg=%h",
                 nm, act.pc, act.instr, act.tk, act.tg, e.pc, e.instr, e.tk, e.tg);
      end
    end
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      if (!rst && ifValid && ifReady) begin
        score("deqA", {ifPc, ifInstr, ifPredTaken, ifPredTarget}, qa);
        deqA++;
      end
      if (!rstB && ifValidB && readyB) begin
        score("deqB", {ifPcB, ifInstrB, ifPredTakenB, ifPredTargetB}, qb);
        deqB++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst = 1'b1;
    ifReady = 1'b0;
    cyc();
  endtask

  initial begin
    int d0;
    rst = 1'b1; rstB = 1'b1;
    ifReady = 1'b0; readyB = 1'b0;
    redirect = 1'b0; redirectPc = 32'h0;
    hit_en = 1'b0; hit_pc = 32'h0; hit_tgt = 32'h0;
    fork mon_loop(); join_none
    repeat (2) cyc();

    chk("rst_ifValid", {31'b0, ifValid}, 32'h0);
    chk("rst_bpPc", bpPc, 32'h0);
    chk("rst_imemAddr", imemAddr, 32'h0);
    chk("rst_ifPc", ifPc, 32'h0);
    chk("rst_ifInstr", ifInstr, 32'h0);
    chk("rst_ifPredTaken", {31'b0, ifPredTaken}, 32'h0);
    chk("rst_ifPredTarget", ifPredTarget, 32'h0);
    chk("rstB_bpPc", bpPcB, 32'hFFFF_FFFC);
    chk("rstB_ifValid", {31'b0, ifValidB}, 32'h0);

    // Streaming from reset
    qa.push_back(mk(32'h0, 1'b0, 32'h0));
    qa.push_back(mk(32'h4, 1'b0, 32'h0));
    qa.push_back(mk(32'h8, 1'b0, 32'h0));
    qa.push_back(mk(32'hC, 1'b0, 32'h0));
    d0 = deqA;
    ifReady = 1'b1; rst = 1'b0;
    chk("t1_first_bpPc", bpPc, 32'h0);
    repeat (5) cyc();
    ifReady = 1'b0;
    chk("t1_deqs", deqA - d0, 32'd4);
    chk("t1_bpPc", bpPc, 32'h14);

    // Backpressure fills the FIFO, then drains in order
    rst = 1'b1;
    #1 chk("t2_async_rst_ifValid", {31'b0, ifValid}, 32'h0);
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    chk("t2_stall_bpPc", bpPc, 32'h8);
    chk("t2_stall_ifValid", {31'b0, ifValid}, 32'h1);
    chk("t2_stall_ifPc", ifPc, 32'h0);
    qa.push_back(mk(32'h0, 1'b0, 32'h0));
    qa.push_back(mk(32'h4, 1'b0, 32'h0));
    qa.push_back(mk(32'h8, 1'b0, 32'h0));
    d0 = deqA;
    ifReady = 1'b1;
    repeat (3) cyc();
    ifReady = 1'b0;
    chk("t2_deqs", deqA - d0, 32'd3);

    // Predicted-taken branch at PC 8
    reset_a();
    hit_pc = 32'h8; hit_tgt = 32'h0000_0103; hit_en = 1'b1;
    qa.push_back(mk(32'h0, 1'b0, 32'h0));
    qa.push_back(mk(32'h4, 1'b0, 32'h0));
    qa.push_back(mk(32'h8, 1'b1, 32'h103));
    qa.push_back(mk(32'h100, 1'b0, 32'h0));
    qa.push_back(mk(32'h104, 1'b0, 32'h0));
    d0 = deqA;
    ifReady = 1'b1; rst = 1'b0;
    repeat (3) cyc();
    chk("t3_bpPc_target", bpPc, 32'h100);
    repeat (3) cyc();
    ifReady = 1'b0; hit_en = 1'b0;
    chk("t3_deqs", deqA - d0, 32'd5);

    // Redirect with a full FIFO and a coincident dequeue
    reset_a();
    rst = 1'b0;
    repeat (3) cyc();
    qa.push_back(mk(32'h0, 1'b0, 32'h0));
    qa.push_back(mk(32'h200, 1'b0, 32'h0));
    qa.push_back(mk(32'h204, 1'b0, 32'h0));
    d0 = deqA;
    ifReady = 1'b1; redirect = 1'b1; redirectPc = 32'h0000_0202;
    cyc();
    redirect = 1'b0;
    chk("t4_redir_ifValid", {31'b0, ifValid}, 32'h0);
    chk("t4_redir_bpPc", bpPc, 32'h200);
    cyc();
    chk("t4_resume_ifValid", {31'b0, ifValid}, 32'h1);
    chk("t4_resume_ifPc", ifPc, 32'h200);
    repeat (2) cyc();
    ifReady = 1'b0;
    chk("t4_deqs", deqA - d0, 32'd3);

    // Asynchronous reset mid-cycle with two entries buffered
    reset_a();
    rst = 1'b0;
    repeat (3) cyc();
    chk("t5_full_ifValid", {31'b0, ifValid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_ifValid", {31'b0, ifValid}, 32'h0);
    chk("t5_async_bpPc", bpPc, 32'h0);
    cyc();

    // PC wrap from 0xFFFF_FFFC
    qb.push_back(mk(32'hFFFF_FFFC, 1'b0, 32'h0));
    qb.push_back(mk(32'h0, 1'b0, 32'h0));
    qb.push_back(mk(32'h4, 1'b0, 32'h0));
    d0 = deqB;
    rstB = 1'b0; readyB = 1'b1;
    repeat (4) cyc();
    readyB = 1'b0;
    chk("t6_deqs", deqB - d0, 32'd3);
    chk("t6_bpPc", bpPcB, 32'hC);

    cyc();
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port bpPc, output, 32 bits: current PC presented to the branch predictor fetch lookup.
REQ-005 Port bpHit, input, 1 bit: predictor reports a predicted-taken hit for bpPc, same cycle.
REQ-006 Port bpTarget, input, 32 bits: predicted target for bpPc, same cycle.
REQ-007 Port imemAddr, output, 32 bits: instruction memory address; equals bpPc.
REQ-008 Port imemRdata, input, 32 bits: instruction word at imemAddr, combinational same-cycle read.
REQ-009 Port redirect, input, 1 bit: EX-stage mispredict/flush request.
REQ-010 Port redirectPc, input, 32 bits: corrected PC accompanying redirect.
REQ-011 Port ifValid, output, 1 bit: head entry available to decode.
REQ-012 Port ifReady, input, 1 bit: decode accepts the head entry this cycle.
REQ-013 Port ifInstr, output, 32 bits: instruction word of the head entry.
REQ-014 Port ifPc, output, 32 bits: PC of the head entry.
REQ-015 Port ifPredTaken, output, 1 bit: prediction taken flag of the head entry, carried to EX.
REQ-016 Port ifPredTarget, output, 32 bits: predicted target of the head entry, carried to EX.

Function
REQ-017 State: 32-bit pc register plus a 2-entry FIFO of {pc, instr, predTaken, predTarget} with a 2-bit count (0..2).
REQ-018 bpPc and imemAddr are driven combinationally from pc.
REQ-019 deq = ifValid && ifReady; fetchEn = (count < 2) || deq.
REQ-020 With fetchEn=1 and redirect=0, the block enqueues {pc, imemRdata, bpHit, bpTarget} at the tail and loads pc with next PC.
REQ-021 Next PC = {bpTarget[31:2], 2'b00} when bpHit=1; otherwise pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-022 With fetchEn=0 and redirect=0, pc holds and nothing is enqueued (stall).
REQ-023 Simultaneous enqueue and dequeue at count=2 or count=1 leaves count unchanged and preserves FIFO order.
REQ-024 Dequeue at count=0 does not occur; enqueue into an empty FIFO is visible on ifValid the next cycle (1-cycle fetch-to-decode latency, no bypass).
REQ-025 ifValid = (count != 0); ifInstr/ifPc/ifPredTaken/ifPredTarget show the head entry and are held stable while ifValid=1 and ifReady=0.
REQ-026 redirect=1 has priority over all other events: count cleared to 0, no enqueue that cycle, pc loaded with {redirectPc[31:2], 2'b00}.
REQ-027 A redirect coinciding with a dequeue is legal; the dequeued entry counts as consumed, all remaining entries are discarded.
REQ-028 The cycle after a redirect, bpPc equals the redirect PC and fetch resumes under REQ-020.
REQ-029 Payload outputs are don't-care while ifValid=0, but stay X-free after reset.

Reset
REQ-030 While rst=1: pc=RESET_PC, count=0, ifValid=0, FIFO payload registers cleared to 0; asserting rst mid-operation discards all in-flight entries immediately.
REQ-031 The first fetch after rst deasserts uses bpPc=RESET_PC.

Verification
REQ-032 Reset then ifReady=1, bpHit=0, imem returns addr^32'hA5A5_0000 -> ifPc sequence 0,4,8,12 on consecutive cycles, ifValid high from the second cycle.
REQ-033 ifReady=0 for 5 cycles from reset -> exactly 2 entries (PC 0,4) buffered, bpPc holds at 8; release -> ifPc 0,4,8 in order, with none lost or duplicated.
REQ-034 bpHit=1, bpTarget=32'h0000_0103 at pc=8 -> entry for PC 8 has ifPredTaken=1, ifPredTarget=32'h103; next bpPc=32'h100.
REQ-035 redirect=1, redirectPc=32'h200 with count=2 and ifReady=1 -> next cycle ifValid=0, bpPc=32'h200; following cycle ifPc=32'h200.
REQ-036 RESET_PC=32'hFFFF_FFFC, no hits -> ifPc 32'hFFFF_FFFC then 32'h0000_0000.
REQ-037 rst pulsed asynchronously mid-cycle with count=2 -> ifValid drops without waiting for a clock edge; bpPc=RESET_PC.
